wrr_burst_arbiter: RTL and testbench

//   N-way weighted round-robin arbiter with burst locking and a downstream ready handshake.
//   The winner keeps the grant for up to quota[i] accepted beats, then rotates priority.

---
 rtl/wrr_burst_arbiter_if.sv | 26 ++
 rtl/wrr_burst_arbiter.sv | 109 ++++++++++
 tb/tb_wrr_burst_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/wrr_burst_arbiter_if.sv
// Request/grant bundle between requesters and the weighted round-robin burst arbiter.
// The arbiter connects through the slave modport; the requester side uses master.
interface wrr_burst_arbiter_if #(
   parameter int N  = 4,
   parameter int QW = 4
) ();
   localparam int IW = $clog2(N);

   logic [N-1:0]    req;
   logic [N*QW-1:0] quota;
   logic            ready;
   logic [N-1:0]    gnt;
   logic            gnt_valid;
   logic [IW-1:0]   gnt_id;
   logic [QW-1:0]   credit;

   modport master (
      output req, quota, ready,
      input  gnt, gnt_valid, gnt_id, credit
   );

   modport slave (
      input  req, quota, ready,
      output gnt, gnt_valid, gnt_id, credit
   );
endinterface

// File: rtl/wrr_burst_arbiter.sv
// N-way weighted round-robin arbiter: the winner holds a registered grant for up to
// max(quota,1) accepted beats, then priority rotates past it with no idle bubble.
module wrr_burst_arbiter #(
   parameter int N  = 4,
   parameter int QW = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   wrr_burst_arbiter_if.slave bus
);
   localparam int IW = $clog2(N);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t        r_state, w_nxt_state;
   logic [IW-1:0] r_ptr, w_nxt_ptr;
   logic [IW-1:0] r_gnt_id, w_nxt_id;
   logic [QW-1:0] r_credit, w_nxt_credit;
   logic [N-1:0]  r_gnt;
   logic [IW-1:0] w_arb_ptr, w_sel;
   logic [QW-1:0] w_sel_quota;
   logic          w_found, w_beat, w_release;

   function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] i);
      return (i == IW'(N-1)) ? '0 : i + 1'b1;
   endfunction

   // Walk from the highest index down so the first set bit in search order wins.
   function automatic logic [IW:0] f_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
      logic [IW:0] res;
      int          j;
      res = '0;
      for (int k = N-1; k >= 0; k--) begin
         j = int'(p) + k;
         if (j >= N) j = j - N;
         if (r[j]) res = {1'b1, IW'(j)};
      end
      return res;
   endfunction

   function automatic logic [QW-1:0] f_qmax(input logic [QW-1:0] q);
      return (q == '0) ? QW'(1) : q;
   endfunction

   // On release the search starts just past the current owner, otherwise at ptr.
   assign w_arb_ptr            = (r_state == S_GRANT) ? f_inc(r_gnt_id) : r_ptr;
   assign {w_found, w_sel}     = f_pick(bus.req, w_arb_ptr);
   assign w_sel_quota          = bus.quota[int'(w_sel)*QW +: QW];
   assign w_beat               = bus.req[r_gnt_id] & bus.ready;
   assign w_release            = ~bus.req[r_gnt_id] | (w_beat & (r_credit == QW'(1)));

   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_ptr    = r_ptr;
      w_nxt_id     = r_gnt_id;
      w_nxt_credit = r_credit;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_nxt_state  = S_GRANT;
               w_nxt_id     = w_sel;
               w_nxt_credit = f_qmax(w_sel_quota);
            end
         end
         S_GRANT: begin
            if (w_release) begin
               w_nxt_ptr = w_arb_ptr;
               if (w_found) begin
                  w_nxt_state  = S_GRANT;
                  w_nxt_id     = w_sel;
                  w_nxt_credit = f_qmax(w_sel_quota);
               end else begin
                  w_nxt_state  = S_IDLE;
                  w_nxt_id     = '0;
                  w_nxt_credit = '0;
               end
            end else if (w_beat) begin
               w_nxt_credit = r_credit - 1'b1;
            end
         end
         default: begin
            w_nxt_state  = S_IDLE;
            w_nxt_id     = '0;
            w_nxt_credit = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_ptr    <= '0;
         r_gnt_id <= '0;
         r_credit <= '0;
         r_gnt    <= '0;
      end else begin
         r_state  <= w_nxt_state;
         r_ptr    <= w_nxt_ptr;
         r_gnt_id <= w_nxt_id;
         r_credit <= w_nxt_credit;
         r_gnt    <= (w_nxt_state == S_GRANT) ? (N'(1) << w_nxt_id) : '0;
      end
   end

   assign bus.gnt       = r_gnt;
   assign bus.gnt_valid = |r_gnt;
   assign bus.gnt_id    = r_gnt_id;
   assign bus.credit    = r_credit;
endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Bench for wrr_burst_arbiter: directed scenarios plus random traffic, each cycle
// compared against an integer-level model of the weighted round-robin rules.
module tb_wrr_burst_arbiter;
   localparam int N  = 4;
   localparam int QW = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model state: owner index (-1 = idle), remaining beats, priority pointer.
   int m_sel    = -1;
   int m_credit = 0;
   int m_ptr    = 0;

   wrr_burst_arbiter_if #(.N(N), .QW(QW)) bus ();

   wrr_burst_arbiter #(.N(N), .QW(QW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic int qv(input int i);
      int q;
      q = int'(bus.quota[i*QW +: QW]);
      return (q == 0) ? 1 : q;
   endfunction

   task automatic model_edge();
      int w;
      bit b;
      if (m_sel < 0) begin
         w = pick(bus.req, m_ptr);
         if (w >= 0) begin
            m_sel    = w;
            m_credit = qv(w);
         end
      end else begin
         b = bus.req[m_sel] && bus.ready;
         if (!bus.req[m_sel] || (b && m_credit == 1)) begin
            m_ptr    = (m_sel + 1) % N;
            w        = pick(bus.req, m_ptr);
            m_sel    = w;
            m_credit = (w >= 0) ? qv(w) : 0;
         end else if (b) begin
            m_credit = m_credit - 1;
         end
      end
   endtask

   task automatic model_reset();
      m_sel    = -1;
      m_credit = 0;
      m_ptr    = 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("gnt",       32'(bus.gnt),       (m_sel >= 0) ? (32'd1 << m_sel) : 32'd0);
      chk("gnt_valid", 32'(bus.gnt_valid), (m_sel >= 0) ? 32'd1 : 32'd0);
      chk("gnt_id",    32'(bus.gnt_id),    (m_sel >= 0) ? 32'(m_sel) : 32'd0);
      chk("credit",    32'(bus.credit),    32'(m_credit));
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic set_q(input int i, input int v);
      bus.quota[i*QW +: QW] = QW'(v);
   endtask

   // Asserted mid-cycle so the asynchronous clear is observed before any edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0] t2_exp [5];
      t2_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      bus.req   = '0;
      bus.quota = '0;
      bus.ready = 1'b0;
      #2;
      do_reset();

      // Lone requester with quota 3: credit cycles 3,2,1 with back-to-back re-grant.
      set_q(2, 3);
      bus.req   = 4'b0100;
      bus.ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("t1_gnt",    32'(bus.gnt),    32'h4);
         chk("t1_credit", 32'(bus.credit), 32'(3 - (i % 3)));
      end

      // All requesting with quota 1: one grant per cycle in rotation.
      do_reset();
      bus.quota = '0;
      for (int i = 0; i < N; i++) set_q(i, 1);
      bus.req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t2_gnt", 32'(bus.gnt), 32'(t2_exp[i]));
      end

      // Weighted pair plus a three-cycle backpressure freeze.
      do_reset();
      set_q(0, 2);
      set_q(1, 1);
      bus.req = 4'b0011;
      step();
      chk("t3_gnt_a",    32'(bus.gnt),    32'h1);
      chk("t3_credit_a", 32'(bus.credit), 32'd2);
      step();
      chk("t3_credit_b", 32'(bus.credit), 32'd1);
      bus.ready = 1'b0;
      repeat (3) begin
         step();
         chk("t3_hold_gnt",    32'(bus.gnt),    32'h1);
         chk("t3_hold_credit", 32'(bus.credit), 32'd1);
      end
      bus.ready = 1'b1;
      step();
      chk("t3_gnt_c", 32'(bus.gnt), 32'h2);
      step();
      chk("t3_gnt_d",    32'(bus.gnt),    32'h1);
      chk("t3_credit_d", 32'(bus.credit), 32'd2);

      // Owner drops its request early; next winner is searched from owner+1.
      do_reset();
      set_q(1, 3);
      set_q(3, 2);
      bus.req = 4'b0010;
      step();
      chk("t4_gnt_a",    32'(bus.gnt),    32'h2);
      chk("t4_credit_a", 32'(bus.credit), 32'd3);
      bus.req = 4'b1001;
      step();
      chk("t4_gnt_b",    32'(bus.gnt),    32'h8);
      chk("t4_credit_b", 32'(bus.credit), 32'd2);
      bus.req = 4'b0000;
      step();
      chk("t4_idle", 32'(bus.gnt_valid), 32'd0);

      // Zero quota behaves as one.
      do_reset();
      set_q(3, 0);
      bus.req = 4'b1000;
      repeat (2) begin
         step();
         chk("t5_gnt",    32'(bus.gnt),    32'h8);
         chk("t5_credit", 32'(bus.credit), 32'd1);
      end

      // Asynchronous reset mid-burst, then arbitration restarts from index 0.
      do_reset();
      set_q(0, 3);
      bus.req = 4'b1111;
      step();
      step();
      chk("t6_credit_pre", 32'(bus.credit), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("t6_gnt_rst",    32'(bus.gnt),    32'h0);
      chk("t6_credit_rst", 32'(bus.credit), 32'd0);
      chk("t6_id_rst",     32'(bus.gnt_id), 32'd0);
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
      step();
      chk("t6_gnt_post", 32'(bus.gnt), 32'h1);

      // Random traffic: sticky requests, changing quotas, bursty ready, rare resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) bus.req = N'($urandom);
         bus.quota = (N*QW)'($urandom);
         bus.ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 149) == 0) do_reset();
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
